sr_flag_latch: RTL and testbench
================================

# sr_flag_latch

Clocked set/reset flag latch. A request on `set` latches `q` high, and `q` stays high until `reset` clears it. It also provides an inverted output and single-cycle edge-event pulses. It is used as a sticky status/enable flag beside the VGA timing logic and is fully synchronous to one clock.

## Interface
- `FILTER_LEN`, default 1: consecutive cycles `set` must be sampled high before it takes effect (legal range 1..15).
- `clk` input 1: rising-edge clock; all state updates on this edge only.
- `reset` input 1: synchronous reset and latch clear, active-high; one clock, synchronous, active-high.
- `set` input 1: set request, active-high, level-sensitive.
- `q` output 1: latched flag.
- `q_n` output 1: always the inverse of `q`.
- `rise_p` output 1: one-cycle pulse when `q` goes 0->1.
- `fall_p` output 1: one-cycle pulse when `q` goes 1->0.

## Operation
- State: `q` register, 4-bit filter counter `fcnt`, `rise_p`/`fall_p` registers, optional synchronizer (see Configuration).
- `s_eff` is `set` after the optional synchronizer.
- Reset values: `q`=0, `q_n`=1, `rise_p`=0, `fall_p`=0, `fcnt`=0, synchronizer stages=0.
- Power-up/initial value before the first reset is the same as the reset values.
- Priority at each edge:
  - If `reset`=1: clear to reset values; `fall_p`=1 if `q` was 1, else 0. Reset dominates `set` when both are high.
  - Else if `s_eff`=1: `fcnt` increments, saturating at `FILTER_LEN`. When the incremented value reaches `FILTER_LEN` and `q`=0, set `q`=1 and `rise_p`=1.
  - Else (`s_eff`=0): `fcnt`=0; `q` holds.
- `q`=1 with `set` high is a no-op: `q` stays 1, no pulse.
- Dropping `set` never clears `q`; only `reset` clears it.
- `rise_p`/`fall_p` are 0 on every edge where no transition occurs. They are never both 1.
- `FILTER_LEN`=1: a single sampled-high `set` sets `q`; `fcnt` is effectively unused.
- A `set` burst shorter than `FILTER_LEN` cycles is ignored, and the count restarts from 0.

## Timing
- Set latency, macro off: `q` rises at the `FILTER_LEN`-th consecutive rising edge sampling `set`=1.
- Clear latency: `q` falls at the first rising edge sampling `reset`=1.
- `rise_p`/`fall_p` assert on the same edge `q` changes and deassert at the next edge.
- Reset mid-filter: `fcnt` is cleared; a fresh `FILTER_LEN` run is needed after `reset` drops.
- `reset` held high: `q`=0 throughout regardless of `set`.
- Release with `set` already high: counting starts at the first edge with `reset`=0.
- No combinational path from any input to any output. `q_n` is derived from the `q` register.

## Configuration
- Macro `SR_FLAG_LATCH_SYNC_EN`.
- Defined:
  - `set` passes through a 2-flop synchronizer (reset to 0) before the filter, for asynchronous sources.
  - Set latency grows by 2 cycles, to `FILTER_LEN`+2 edges.
  - `reset` is not synchronized; clear latency is unchanged.
- Undefined: `s_eff` = `set` directly; no synchronizer flops exist.

## Test plan
- Clock 10 ns, `FILTER_LEN`=1, macro off.
  - Hold `reset`=1 2 cycles -> `q`=0, `q_n`=1, pulses 0.
  - Then `reset`=0, `set`=1 for 50 ns -> `q`=1 after the first edge, `rise_p`=1 for exactly one cycle.
- From `q`=1: `reset`=1, `set`=0 for 50 ns -> `q`=0 at the first edge, `fall_p`=1 for one cycle, `q` stays 0.
- Then `reset`=0, `set`=1 for 50 ns -> `q` returns to 1 with one `rise_p`. Drop `set` to 0 -> `q` stays 1.
- `reset`=1 and `set`=1 together for 3 cycles -> `q`=0 throughout. Release `reset` with `set`=1 -> `q`=1 one edge later.
- `FILTER_LEN`=4:
  - `set` high 3 cycles, low 1, high 4 -> `q` stays 0 through the 3-cycle burst.
  - `q` rises on the 4th edge of the second burst.
- Macro on, `FILTER_LEN`=1: `set` high one edge before edge N -> `q` rises at edge N+2; `reset` still clears in 1 edge.

Source files
------------

// File: rtl/sr_flag_latch.sv
// -----------------------------------------------------------------------------
// sr_flag_latch
//
// Clocked set/reset flag latch used as a sticky status/enable flag beside the
// VGA timing logic. A qualified set request latches q high; only reset clears
// it. Single-cycle pulses mark each 0->1 and 1->0 transition of q.
//
// Optional feature:
//   SR_FLAG_LATCH_SYNC_EN - when defined, set passes through a 2-flop
//                           synchronizer before the filter (set latency grows
//                           by two edges; reset is not synchronized).
//
// Parameters:
//   FILTER_LEN  consecutive sampled-high cycles of set needed (1..15)
//
// Ports:
//   clk     in   rising-edge clock, the only timing reference
//   reset   in   synchronous active-high clear, dominates set
//   set     in   active-high level-sensitive set request
//   q       out  latched flag (registered)
//   q_n     out  inverse of q (derived from the q register)
//   rise_p  out  one-cycle pulse on the edge q goes 0->1
//   fall_p  out  one-cycle pulse on the edge q goes 1->0
//
// Handshake: none; set and reset are plain level inputs sampled every edge.
// -----------------------------------------------------------------------------
module sr_flag_latch #(
    parameter int FILTER_LEN = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic set,
    output logic q,
    output logic q_n,
    output logic rise_p,
    output logic fall_p
);

    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("sr_flag_latch: FILTER_LEN must be in 1..15");
    end

    localparam logic [3:0] FLEN = 4'(FILTER_LEN);

    // Declaration values give the same power-up state as reset.
    logic       q_r      = 1'b0;
    logic       rise_r   = 1'b0;
    logic       fall_r   = 1'b0;
    logic [3:0] fcnt     = 4'd0;
    logic       s_eff;
    logic [3:0] fcnt_inc;

`ifdef SR_FLAG_LATCH_SYNC_EN
    // Two-flop synchronizer for asynchronous set sources.
    logic sync1 = 1'b0;
    logic sync2 = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= set;
            sync2 <= sync1;
        end
    end

    assign s_eff = sync2;
`else
    assign s_eff = set;
`endif

    // Saturating increment; the saturated value keeps the counter from
    // wrapping while set is held high after q is already latched.
    always_comb begin
        fcnt_inc = fcnt;
        if (fcnt >= FLEN) begin
            fcnt_inc = FLEN;
        end else begin
            fcnt_inc = fcnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r    <= 1'b0;
            fcnt   <= 4'd0;
            rise_r <= 1'b0;
            // A falling pulse only if the flag was actually set.
            fall_r <= q_r;
        end else if (s_eff) begin
            fcnt   <= fcnt_inc;
            fall_r <= 1'b0;
            if (fcnt_inc == FLEN && !q_r) begin
                q_r    <= 1'b1;
                rise_r <= 1'b1;
            end else begin
                rise_r <= 1'b0;
            end
        end else begin
            // A gap in set restarts the filter; q holds.
            fcnt   <= 4'd0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end
    end

    assign q      = q_r;
    assign q_n    = ~q_r;
    assign rise_p = rise_r;
    assign fall_p = fall_r;

endmodule

// File: tb/tb_sr_flag_latch.sv
// -----------------------------------------------------------------------------
// tb_sr_flag_latch
//
// Drives two instances (FILTER_LEN=1 and FILTER_LEN=4) from one clock with a
// directed sequence followed by random set/reset traffic, and compares every
// output after each edge against a history-based reference model.
// -----------------------------------------------------------------------------
module tb_sr_flag_latch;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1 = 1'b1, set1 = 1'b0;
    logic rst4 = 1'b1, set4 = 1'b0;
    logic q1, qn1, r1, f1;
    logic q4, qn4, r4, f4;

    sr_flag_latch #(.FILTER_LEN(1)) u_dut1 (
        .clk(clk), .reset(rst1), .set(set1),
        .q(q1), .q_n(qn1), .rise_p(r1), .fall_p(f1)
    );

    sr_flag_latch #(.FILTER_LEN(4)) u_dut4 (
        .clk(clk), .reset(rst4), .set(set4),
        .q(q4), .q_n(qn4), .rise_p(r4), .fall_p(f4)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Model keeps the sampled (effective) set history since the last reset,
    // most recent first. q latches once the most recent FILTER_LEN samples
    // since reset are all high.
    bit m_q    [2];
    bit m_rise [2];
    bit m_fall [2];
    bit hist   [2][16];
    int hvalid [2];
    bit pipe   [2][2];   // only used when the synchronizer is built in

    task automatic model_edge(input int k, input bit rst, input bit s, input int len);
        bit s_eff;
        bit all_high;
        if (rst) begin
            m_fall[k] = m_q[k];
            m_rise[k] = 1'b0;
            m_q[k]    = 1'b0;
            hvalid[k] = 0;
            pipe[k][0] = 1'b0;
            pipe[k][1] = 1'b0;
        end else begin
`ifdef SR_FLAG_LATCH_SYNC_EN
            s_eff = pipe[k][1];
            pipe[k][1] = pipe[k][0];
            pipe[k][0] = s;
`else
            s_eff = s;
`endif
            for (int i = 15; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = s_eff;
            if (hvalid[k] < 16) hvalid[k]++;
            all_high = (hvalid[k] >= len);
            for (int i = 0; i < len; i++) if (!hist[k][i]) all_high = 1'b0;
            m_fall[k] = 1'b0;
            if (all_high && !m_q[k]) begin
                m_q[k]    = 1'b1;
                m_rise[k] = 1'b1;
            end else begin
                m_rise[k] = 1'b0;
            end
        end
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("q1",      q1,  m_q[0]);
        check("q_n1",    qn1, ~m_q[0]);
        check("rise_p1", r1,  m_rise[0]);
        check("fall_p1", f1,  m_fall[0]);
        check("q4",      q4,  m_q[1]);
        check("q_n4",    qn4, ~m_q[1]);
        check("rise_p4", r4,  m_rise[1]);
        check("fall_p4", f4,  m_fall[1]);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 ns after an edge; outputs are checked 1 ns after it.
    task automatic step(input bit a_r, input bit a_s, input bit b_r, input bit b_s);
        rst1 = a_r; set1 = a_s;
        rst4 = b_r; set4 = b_s;
        @(posedge clk);
        model_edge(0, a_r, a_s, 1);
        model_edge(1, b_r, b_s, 4);
        #1;
        check_all();
    endtask

    task automatic step_both(input bit r, input bit s, input int n);
        for (int i = 0; i < n; i++) step(r, s, r, s);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_q[k] = 0; m_rise[k] = 0; m_fall[k] = 0; hvalid[k] = 0;
            pipe[k][0] = 0; pipe[k][1] = 0;
            for (int i = 0; i < 16; i++) hist[k][i] = 0;
        end

        // Power-up state equals reset state.
        #1;
        check_all();

        // Reset for two cycles.
        step_both(1'b1, 1'b0, 2);
        // Set for 50 ns: L=1 rises at first edge, L=4 at fourth.
        step_both(1'b0, 1'b1, 5);
        // Reset with set low: falls at first edge, stays low.
        step_both(1'b1, 1'b0, 5);
        // Set again, then drop set: q must hold.
        step_both(1'b0, 1'b1, 5);
        step_both(1'b0, 1'b0, 3);
        // Reset and set together: reset dominates.
        step_both(1'b1, 1'b1, 3);
        // Release reset with set held: counting starts immediately.
        step_both(1'b0, 1'b1, 5);
        // Reset mid-filter on the L=4 instance, then 3-high/1-low/4-high bursts.
        step_both(1'b1, 1'b0, 1);
        step_both(1'b0, 1'b1, 2);
        step_both(1'b1, 1'b1, 1);
        step_both(1'b0, 1'b1, 3);
        step_both(1'b0, 1'b0, 1);
        step_both(1'b0, 1'b1, 4);
        step_both(1'b0, 1'b0, 2);

        // Random traffic: rare resets, set biased high so L=4 runs complete.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 4) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
